// File: rtl/svi_sdram_arbiter.sv
// svi_sdram_arbiter: shares the single byte-wide SDRAM command port between
// HPS download writes, Z80 RAM accesses and cassette-image reads.
//
// Optional feature macro: SVI_CAS_SDRAM_EN
//   defined     -> CAS read port is live, with CPU-starvation protection
//   not defined -> CAS port inert (cas_dout/cas_valid tied low), DL > CPU only
//
// Ports:
//   clk_sys, reset_n          system clock, async active-low reset
//   dl_wr/dl_addr/dl_data     download write strobe, address, byte
//   dl_wait                   download back-pressure (pending write)
//   cpu_rd/cpu_we/cpu_addr/cpu_din   Z80 RAM access levels, address, data
//   cpu_dout, cpu_wait        read data register, Z80 wait line
//   cas_rd/cas_addr           CAS image read strobe and address
//   cas_dout, cas_valid       CAS read data and its one-cycle update pulse
//   mem_addr/mem_din/mem_rd/mem_we   SDRAM controller command
//   mem_ack/mem_dout          SDRAM controller completion and read data
module svi_sdram_arbiter #(
  parameter logic [24:0] CAS_BASE   = 25'h0100000,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_wr,
  input  logic [17:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  input  logic        cas_rd,
  input  logic [17:0] cas_addr,
  output logic [7:0]  cas_dout,
  output logic        cas_valid,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_dout
);

  localparam int unsigned AW = 18;
  localparam int unsigned MW = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_CAS} owner_t;

  state_t        state, state_nxt;
  owner_t        owner;
  logic          own_wr;

  logic          dl_p, cpu_p, cas_p;
  logic [AW-1:0] dl_addr_q, cpu_addr_q, cas_addr_q;
  logic [DW-1:0] dl_data_q, cpu_din_q;
  logic          cpu_wr_q;
  logic          cpu_req_q;

  logic          cpu_edge_c;
  logic          starve_hit_c;
  logic          grant_dl_c, grant_cpu_c, grant_cas_c, done_c;
  logic          clr_dl_c, clr_cpu_c, clr_cas_c;

  // Rising edge of the combined CPU strobe starts a new access
  assign cpu_edge_c = (cpu_rd | cpu_we) & ~cpu_req_q;

  assign dl_wait  = dl_p;
  assign cpu_wait = cpu_p | cpu_edge_c;

  assign clr_dl_c  = done_c & (owner == OWN_DL);
  assign clr_cpu_c = done_c & (owner == OWN_CPU);
  assign clr_cas_c = done_c & (owner == OWN_CAS);

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dl_p || cpu_p || cas_p) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant / completion decode; starved CAS may jump ahead of CPU, never DL
  always_comb begin
    grant_dl_c  = 1'b0;
    grant_cpu_c = 1'b0;
    grant_cas_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (dl_p)                      grant_dl_c  = 1'b1;
        else if (cas_p && starve_hit_c) grant_cas_c = 1'b1;
        else if (cpu_p)                grant_cpu_c = 1'b1;
        else if (cas_p)                grant_cas_c = 1'b1;
      end
      S_WAIT:  done_c = mem_ack;
      default: ;
    endcase
  end

  // Download and CPU request capture; a strobe in the completion cycle re-arms
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_p       <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      cpu_p      <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_wr_q   <= 1'b0;
      cpu_req_q  <= 1'b0;
    end else begin
      cpu_req_q <= cpu_rd | cpu_we;
      if (dl_wr && (!dl_p || clr_dl_c)) begin
        dl_addr_q <= dl_addr;
        dl_data_q <= dl_data;
      end
      dl_p <= dl_wr | (dl_p & ~clr_dl_c);
      if (cpu_edge_c && (!cpu_p || clr_cpu_c)) begin
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
        cpu_wr_q   <= cpu_we;
      end
      cpu_p <= cpu_edge_c | (cpu_p & ~clr_cpu_c);
    end
  end

`ifdef SVI_CAS_SDRAM_EN
  logic [SW-1:0] starve_cnt;

  assign starve_hit_c = (starve_cnt == SW'(STARVE_MAX));

  // CAS request capture and starvation counter
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cas_p      <= 1'b0;
      cas_addr_q <= '0;
      starve_cnt <= '0;
    end else begin
      if (cas_rd && (!cas_p || clr_cas_c)) cas_addr_q <= cas_addr;
      cas_p <= cas_rd | (cas_p & ~clr_cas_c);
      if (grant_cas_c || !cas_p)
        starve_cnt <= '0;
      else if (grant_cpu_c && !starve_hit_c)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // CAS read data return
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cas_dout  <= '0;
      cas_valid <= 1'b0;
    end else begin
      cas_valid <= clr_cas_c;
      if (clr_cas_c) cas_dout <= mem_dout;
    end
  end
`else
  logic cas_unused;

  assign cas_p        = 1'b0;
  assign cas_addr_q   = '0;
  assign starve_hit_c = 1'b0;
  assign cas_dout     = '0;
  assign cas_valid    = 1'b0;
  assign cas_unused   = ^{cas_rd, cas_addr, SW'(STARVE_MAX)};
`endif

  // Command register: loaded on grant, pulsed in ISSUE, held through WAIT
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_DL;
      own_wr   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      cpu_dout <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      if (grant_dl_c) begin
        owner    <= OWN_DL;
        own_wr   <= 1'b1;
        mem_addr <= MW'(dl_addr_q);
        mem_din  <= dl_data_q;
        mem_we   <= 1'b1;
      end else if (grant_cpu_c) begin
        owner    <= OWN_CPU;
        own_wr   <= cpu_wr_q;
        mem_addr <= MW'(cpu_addr_q);
        mem_din  <= cpu_din_q;
        mem_we   <= cpu_wr_q;
        mem_rd   <= ~cpu_wr_q;
      end else if (grant_cas_c) begin
        owner    <= OWN_CAS;
        own_wr   <= 1'b0;
        mem_addr <= CAS_BASE + MW'(cas_addr_q);
        mem_din  <= '0;
        mem_rd   <= 1'b1;
      end
      if (clr_cpu_c && !own_wr) cpu_dout <= mem_dout;
    end
  end

endmodule

// File: tb/tb_svi_sdram_arbiter.sv
module tb_svi_sdram_arbiter;

  logic        clk_sys;
  logic        reset_n;
  logic        dl_wr;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        cpu_rd;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        cas_rd;
  logic [17:0] cas_addr;
  logic [7:0]  cas_dout;
  logic        cas_valid;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_rd;
  logic        mem_we;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  int vectors;
  int miscompares;

  svi_sdram_arbiter #(
    .CAS_BASE  (25'h1FFFFFF),
    .STARVE_MAX(8)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .cpu_rd   (cpu_rd),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .cas_rd   (cas_rd),
    .cas_addr (cas_addr),
    .cas_dout (cas_dout),
    .cas_valid(cas_valid),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    dl_wr    = 1'b0; dl_addr  = '0; dl_data = '0;
    cpu_rd   = 1'b0; cpu_we   = 1'b0; cpu_addr = '0; cpu_din = '0;
    cas_rd   = 1'b0; cas_addr = '0;
    mem_ack  = 1'b0; mem_dout = '0;
    repeat (3) tick();
    vectors++;
    if ({dl_wait, cpu_wait, cpu_dout, cas_dout, cas_valid, mem_addr, mem_din, mem_rd, mem_we} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {dl_wait, cpu_wait, cpu_dout, cas_dout, cas_valid, mem_addr, mem_din, mem_rd, mem_we});
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_cpu_read;
    cpu_addr = 18'h0_8000;
    cpu_rd   = 1'b1;                     // cycle N
    #1;
    vectors++;
    if (cpu_wait !== 1'b1) begin miscompares++; $display("FAIL rd_wait_edge: got %b expected 1", cpu_wait); end
    tick();                              // N+1
    vectors++;
    if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rd_no_early_cmd: got %b expected 0", mem_rd); end
    tick();                              // N+2
    vectors++;
    if ({mem_rd, mem_we, mem_addr} !== {1'b1, 1'b0, 25'h0008000}) begin
      miscompares++;
      $display("FAIL rd_issue: got rd=%b we=%b addr=%h expected rd=1 we=0 addr=0008000", mem_rd, mem_we, mem_addr);
    end
    tick();                              // N+3
    vectors++;
    if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rd_pulse_width: got %b expected 0", mem_rd); end
    repeat (3) tick();                   // N+6
    tick();                              // N+7
    mem_ack = 1'b1; mem_dout = 8'hA5;
    vectors++;
    if (cpu_wait !== 1'b1 || mem_addr !== 25'h0008000) begin
      miscompares++;
      $display("FAIL rd_wait_hold: got wait=%b addr=%h expected wait=1 addr=0008000", cpu_wait, mem_addr);
    end
    tick();                              // N+8
    mem_ack = 1'b0; mem_dout = 8'h00;
    vectors++;
    if (cpu_wait !== 1'b0 || cpu_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_done: got wait=%b dout=%h expected wait=0 dout=a5", cpu_wait, cpu_dout);
    end
    cpu_rd = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write;
    cpu_addr = 18'h3_FFFF; cpu_din = 8'hC3; cpu_we = 1'b1;   // N
    tick();                                                  // N+1
    tick();                                                  // N+2
    vectors++;
    if ({mem_we, mem_rd, mem_addr, mem_din} !== {1'b1, 1'b0, 25'h003FFFF, 8'hC3}) begin
      miscompares++;
      $display("FAIL wr_issue: got we=%b rd=%b addr=%h din=%h expected we=1 rd=0 addr=003ffff din=c3",
               mem_we, mem_rd, mem_addr, mem_din);
    end
    tick();                                                  // N+3
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (cpu_wait !== 1'b0 || cpu_dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL wr_done: got wait=%b dout=%h expected wait=0 dout=a5", cpu_wait, cpu_dout);
    end
    cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_dl_cpu;
    dl_wr = 1'b1; dl_addr = 18'h2_0123; dl_data = 8'h5A;     // N
    cpu_rd = 1'b1; cpu_addr = 18'h0_1234;
    tick();                                                  // N+1
    dl_wr = 1'b0;
    vectors++;
    if ({dl_wait, cpu_wait} !== 2'b11) begin
      miscompares++; $display("FAIL dlcpu_pending: got %b expected 11", {dl_wait, cpu_wait});
    end
    tick();                                                  // N+2
    vectors++;
    if ({mem_we, mem_rd, mem_addr, mem_din} !== {1'b1, 1'b0, 25'h0020123, 8'h5A}) begin
      miscompares++;
      $display("FAIL dlcpu_dl_first: got we=%b rd=%b addr=%h din=%h expected we=1 rd=0 addr=0020123 din=5a",
               mem_we, mem_rd, mem_addr, mem_din);
    end
    tick();                                                  // N+3
    mem_ack = 1'b1;
    tick();                                                  // N+4
    mem_ack = 1'b0;
    vectors++;
    if ({dl_wait, cpu_wait} !== 2'b01) begin
      miscompares++; $display("FAIL dlcpu_dl_clears_first: got %b expected 01", {dl_wait, cpu_wait});
    end
    tick();                                                  // N+5
    vectors++;
    if ({mem_rd, mem_we, mem_addr} !== {1'b1, 1'b0, 25'h0001234}) begin
      miscompares++;
      $display("FAIL dlcpu_cpu_second: got rd=%b we=%b addr=%h expected rd=1 we=0 addr=0001234",
               mem_rd, mem_we, mem_addr);
    end
    mem_ack = 1'b1;                                          // ISSUE: must be ignored
    tick();                                                  // N+6
    vectors++;
    if (cpu_wait !== 1'b1) begin miscompares++; $display("FAIL dlcpu_ack_in_issue: got wait=%b expected 1", cpu_wait); end
    mem_dout = 8'h3C;                                        // ack in WAIT
    tick();                                                  // N+7
    mem_ack = 1'b0; mem_dout = 8'h00;
    vectors++;
    if (cpu_wait !== 1'b0 || cpu_dout !== 8'h3C) begin
      miscompares++;
      $display("FAIL dlcpu_cpu_done: got wait=%b dout=%h expected wait=0 dout=3c", cpu_wait, cpu_dout);
    end
    cpu_rd = 1'b0;
    tick();
  endtask

`ifdef SVI_CAS_SDRAM_EN
  task automatic test_cas_wrap;
    cas_rd = 1'b1; cas_addr = 18'h3_FFFF;                    // N
    tick();                                                  // N+1
    cas_rd = 1'b0;
    tick();                                                  // N+2
    vectors++;
    if ({mem_rd, mem_we, mem_addr} !== {1'b1, 1'b0, 25'h003FFFE}) begin
      miscompares++;
      $display("FAIL cas_wrap_addr: got rd=%b we=%b addr=%h expected rd=1 we=0 addr=003fffe",
               mem_rd, mem_we, mem_addr);
    end
    tick();                                                  // N+3
    mem_ack = 1'b1; mem_dout = 8'h77;
    vectors++;
    if (cas_valid !== 1'b0) begin miscompares++; $display("FAIL cas_valid_early: got %b expected 0", cas_valid); end
    tick();                                                  // N+4
    mem_ack = 1'b0; mem_dout = 8'h00;
    vectors++;
    if (cas_valid !== 1'b1 || cas_dout !== 8'h77) begin
      miscompares++;
      $display("FAIL cas_data: got valid=%b dout=%h expected valid=1 dout=77", cas_valid, cas_dout);
    end
    tick();                                                  // N+5
    vectors++;
    if (cas_valid !== 1'b0) begin miscompares++; $display("FAIL cas_valid_pulse: got %b expected 0", cas_valid); end
    tick();
  endtask

  task automatic test_starve;
    int n;
    cpu_rd = 1'b1; cpu_addr = 18'h0_0100;
    cas_rd = 1'b1; cas_addr = 18'h0_0010;
    tick();
    cas_rd = 1'b0;
    for (int g = 0; g < 9; g++) begin
      n = 0;
      while (!mem_rd && n < 10) begin tick(); n++; end
      vectors++;
      if (g < 8) begin
        if (mem_addr !== 25'h0000100 + 25'(g)) begin
          miscompares++;
          $display("FAIL starve_cpu_grant%0d: got addr=%h expected %h", g, mem_addr, 25'h0000100 + 25'(g));
        end
      end else begin
        if (mem_addr !== 25'h000000F) begin
          miscompares++;
          $display("FAIL starve_cas_grant: got addr=%h expected 000000f", mem_addr);
        end
      end
      if (g == 7) begin
        vectors++;
        if (dut.starve_cnt !== 4'd8) begin
          miscompares++; $display("FAIL starve_cnt_sat: got %0d expected 8", dut.starve_cnt);
        end
      end
      if (g < 8) cpu_rd = 1'b0;
      tick();                                                // WAIT
      mem_ack = 1'b1; mem_dout = 8'(g);
      if (g < 8) begin cpu_rd = 1'b1; cpu_addr = 18'h0_0100 + 18'(g + 1); end
      tick();
      mem_ack = 1'b0; mem_dout = 8'h00;
      if (g == 8) begin
        vectors++;
        if (cas_valid !== 1'b1 || cas_dout !== 8'h08) begin
          miscompares++;
          $display("FAIL starve_cas_data: got valid=%b dout=%h expected valid=1 dout=08", cas_valid, cas_dout);
        end
      end
    end
    n = 0;
    while (!mem_rd && n < 10) begin tick(); n++; end
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== 25'h0000108 || dut.starve_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL starve_after: got rd=%b addr=%h cnt=%0d expected rd=1 addr=0000108 cnt=0",
               mem_rd, mem_addr, dut.starve_cnt);
    end
    cpu_rd = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
  endtask
`else
  task automatic test_cas_disabled;
    cas_rd = 1'b1; cas_addr = 18'h0_0005;
    tick();
    cas_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({mem_rd, mem_we, cas_valid, cas_dout} !== 11'd0) begin
        miscompares++;
        $display("FAIL cas_disabled%0d: got rd=%b we=%b valid=%b dout=%h expected all 0",
                 i, mem_rd, mem_we, cas_valid, cas_dout);
      end
      tick();
    end
  endtask
`endif

  task automatic test_reset_mid_wait;
    dl_wr = 1'b1; dl_addr = 18'h0_0001; dl_data = 8'h11;     // N
    cpu_rd = 1'b1; cpu_addr = 18'h0_0002;
    tick();                                                  // N+1
    dl_wr = 1'b0;
    tick();                                                  // N+2 ISSUE
    tick();                                                  // N+3 WAIT
    cpu_rd  = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({dl_wait, cpu_wait, cpu_dout, cas_dout, cas_valid, mem_addr, mem_din, mem_rd, mem_we} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got %h expected 0",
               {dl_wait, cpu_wait, cpu_dout, cas_dout, cas_valid, mem_addr, mem_din, mem_rd, mem_we});
    end
    tick();
    reset_n = 1'b1;
    tick();
    mem_ack = 1'b1;                                          // late ack in IDLE
    tick();
    mem_ack = 1'b0;
    vectors++;
    if ({dl_wait, cpu_wait, mem_rd, mem_we} !== 4'd0) begin
      miscompares++;
      $display("FAIL late_ack: got %b expected 0000", {dl_wait, cpu_wait, mem_rd, mem_we});
    end
    tick();
    vectors++;
    if ({mem_rd, mem_we} !== 2'd0) begin
      miscompares++; $display("FAIL late_ack_no_issue: got %b expected 00", {mem_rd, mem_we});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dl_cpu();
`ifdef SVI_CAS_SDRAM_EN
    test_cas_wrap();
    test_starve();
`else
    test_cas_disabled();
`endif
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
